// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: front-end for the internal (priority) port of the word memory.
// After reset, or on an I_init pulse, it clears the whole array. It then shares
// the port between requesters A and B using round-robin arbitration and a
// req/gnt handshake. Read data is registered one cycle after the grant.
// Optional feature macro: MEM_ARB_STATS_EN adds 16-bit saturating per-side grant
// counters (O_a_cnt, O_b_cnt).
module mem_arb_ctrl #(
  parameter int C_ADDRSIZE = 10,
  parameter int C_WORDSIZE = 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_init,
  output logic                  O_init_busy,
  input  logic                  I_a_req,
  input  logic                  I_a_we,
  input  logic [C_ADDRSIZE-1:0] I_a_addr,
  input  logic [C_WORDSIZE-1:0] I_a_wdata,
  output logic                  O_a_gnt,
  output logic                  O_a_rvalid,
  output logic [C_WORDSIZE-1:0] O_a_rdata,
  input  logic                  I_b_req,
  input  logic                  I_b_we,
  input  logic [C_ADDRSIZE-1:0] I_b_addr,
  input  logic [C_WORDSIZE-1:0] I_b_wdata,
  output logic                  O_b_gnt,
  output logic                  O_b_rvalid,
  output logic [C_WORDSIZE-1:0] O_b_rdata,
  output logic                  O_mem_wen,
  output logic [C_ADDRSIZE-1:0] O_mem_addr,
  output logic [C_WORDSIZE-1:0] O_mem_wdata,
  input  logic [C_WORDSIZE-1:0] I_mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]           O_a_cnt,
  output logic [15:0]           O_b_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [C_ADDRSIZE-1:0] LAST_ADDR = {C_ADDRSIZE{1'b1}};
  localparam logic [C_ADDRSIZE-1:0] ADDR_ZERO = {C_ADDRSIZE{1'b0}};
  localparam logic [C_ADDRSIZE-1:0] ADDR_ONE  = {{(C_ADDRSIZE-1){1'b0}}, 1'b1};
  localparam logic [C_WORDSIZE-1:0] WORD_ZERO = {C_WORDSIZE{1'b0}};

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [C_ADDRSIZE-1:0]   clr_cnt_r;
  logic [C_ADDRSIZE-1:0]   addr_hold_r;
  logic                    last_b_r;      // 1: B was granted last, so A wins a tie
  logic                    init_busy_r;
  logic                    a_rvalid_r;
  logic                    b_rvalid_r;
  logic [C_WORDSIZE-1:0]   a_rdata_r;
  logic [C_WORDSIZE-1:0]   b_rdata_r;
  logic                    gnt_a_s;
  logic                    gnt_b_s;
  logic                    mem_wen_s;
  logic [C_ADDRSIZE-1:0]   mem_addr_s;
  logic [C_WORDSIZE-1:0]   mem_wdata_s;

  // Next-state, arbitration and memory-port mux.
  always_comb begin
    state_nxt_s = state_r;
    gnt_a_s     = 1'b0;
    gnt_b_s     = 1'b0;
    mem_wen_s   = 1'b0;
    mem_addr_s  = addr_hold_r;
    mem_wdata_s = WORD_ZERO;
    case (state_r)
      ST_INIT: begin
        mem_wen_s   = 1'b1;
        mem_addr_s  = clr_cnt_r;
        mem_wdata_s = WORD_ZERO;
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (I_a_req && (!I_b_req || last_b_r)) begin
          gnt_a_s = 1'b1;
        end else if (I_b_req) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
        if (gnt_a_s) begin
          mem_wen_s   = I_a_we;
          mem_addr_s  = I_a_addr;
          mem_wdata_s = I_a_wdata;
        end else if (gnt_b_s) begin
          mem_wen_s   = I_b_we;
          mem_addr_s  = I_b_addr;
          mem_wdata_s = I_b_wdata;
        end else begin
          mem_wen_s   = 1'b0;
          mem_addr_s  = addr_hold_r;
        end
        // A grant issued in the same cycle as I_init still completes.
        if (I_init) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Control state, clear counter, RR pointer and read-return registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r     <= ST_INIT;
      clr_cnt_r   <= ADDR_ZERO;
      addr_hold_r <= ADDR_ZERO;
      last_b_r    <= 1'b1;
      init_busy_r <= 1'b1;
      a_rvalid_r  <= 1'b0;
      b_rvalid_r  <= 1'b0;
      a_rdata_r   <= WORD_ZERO;
      b_rdata_r   <= WORD_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      init_busy_r <= (state_nxt_s == ST_INIT);
      addr_hold_r <= mem_addr_s;
      // The counter wraps back to zero on the last clear write.
      if (state_r == ST_INIT) begin
        clr_cnt_r <= clr_cnt_r + ADDR_ONE;
      end else if (state_nxt_s == ST_INIT) begin
        clr_cnt_r <= ADDR_ZERO;
      end
      if (gnt_a_s) begin
        last_b_r <= 1'b0;
      end else if (gnt_b_s) begin
        last_b_r <= 1'b1;
      end
      a_rvalid_r <= gnt_a_s & ~I_a_we;
      b_rvalid_r <= gnt_b_s & ~I_b_we;
      if (gnt_a_s && !I_a_we) begin
        a_rdata_r <= I_mem_rdata;
      end
      if (gnt_b_s && !I_b_we) begin
        b_rdata_r <= I_mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] a_cnt_r;
  logic [15:0] b_cnt_r;

  // Saturating grant counters, cleared when a clear sequence starts.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      a_cnt_r <= 16'h0000;
      b_cnt_r <= 16'h0000;
    end else if ((state_r == ST_RUN) && (state_nxt_s == ST_INIT)) begin
      a_cnt_r <= 16'h0000;
      b_cnt_r <= 16'h0000;
    end else begin
      if (gnt_a_s && (a_cnt_r != 16'hFFFF)) begin
        a_cnt_r <= a_cnt_r + 16'h0001;
      end
      if (gnt_b_s && (b_cnt_r != 16'hFFFF)) begin
        b_cnt_r <= b_cnt_r + 16'h0001;
      end
    end
  end

  assign O_a_cnt = a_cnt_r;
  assign O_b_cnt = b_cnt_r;
`endif

  assign O_init_busy = init_busy_r;
  assign O_a_gnt     = gnt_a_s;
  assign O_b_gnt     = gnt_b_s;
  assign O_a_rvalid  = a_rvalid_r;
  assign O_b_rvalid  = b_rvalid_r;
  assign O_a_rdata   = a_rdata_r;
  assign O_b_rdata   = b_rdata_r;
  assign O_mem_wen   = mem_wen_s;
  assign O_mem_addr  = mem_addr_s;
  assign O_mem_wdata = mem_wdata_s;

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
Controller sitting in front of the internal (priority) port of the synchronous word memory. Clears the whole array after reset or on command, then shares the port between two requesters (A, B) with round-robin arbitration and a req/gnt handshake. Returns registered read data one cycle after grant. The external memory port is not touched by this block.

Parameters:
C_ADDRSIZE, 10, memory address width; depth = 2^C_ADDRSIZE words
C_WORDSIZE, 8, memory word width

Ports:
I_clk  in  1  clock, all logic on rising edge
I_rst_n  in  1  asynchronous active-low reset
I_init  in  1  single-cycle pulse: restart array clear (honoured only in IDLE)
O_init_busy  out  1  high while clearing
I_a_req  in  1  requester A access request
I_a_we  in  1  A: 1 = write, 0 = read
I_a_addr  in  C_ADDRSIZE  A address
I_a_wdata  in  C_WORDSIZE  A write data
O_a_gnt  out  1  A granted this cycle (combinational)
O_a_rvalid  out  1  A read data valid (one-cycle pulse)
O_a_rdata  out  C_WORDSIZE  A read data (registered)
I_b_req, I_b_we, I_b_addr, I_b_wdata, O_b_gnt, O_b_rvalid, O_b_rdata: same as A for requester B
O_mem_wen  out  1  to memory I_wen
O_mem_addr  out  C_ADDRSIZE  to memory I_addr
O_mem_wdata  out  C_WORDSIZE  to memory I_wdata
I_mem_rdata  in  C_WORDSIZE  from memory O_data (combinational read of O_mem_addr)

Behaviour:
- Reset values: state INIT, clear counter 0, O_init_busy 1, rvalid 0, rdata 0, RR pointer = A preferred; O_a_gnt/O_b_gnt 0 (forced low in INIT).
- States: INIT, IDLE/SERVE (single serve state "RUN").
- INIT: each cycle O_mem_wen=1, O_mem_addr=counter, O_mem_wdata=0; counter increments. On cycle with counter = 2^C_ADDRSIZE-1 the write occurs, then -> RUN, O_init_busy drops next cycle. Clear takes exactly 2^C_ADDRSIZE cycles. No grants in INIT; requests stall (held by requester).
- RUN: I_init pulse -> INIT (counter reset to 0) on next edge; a grant asserted in that same cycle still completes. I_init ignored while in INIT.
- Arbitration (RUN, combinational): only one requesting -> grant it. Both -> grant side opposite last-granted (pointer). Pointer updates to granted side on each grant edge; unchanged when no grant.
- Granted cycle: O_mem_addr/O_mem_we/O_mem_wdata = granted requester's fields; O_mem_wen = we. No grant -> O_mem_wen 0, O_mem_addr holds last value.
- Requester holds req/we/addr/wdata stable until gnt seen; may drop req after gnt or keep it high for back-to-back access (one access per gnt cycle).
- Read: at grant edge, I_mem_rdata latched into O_x_rdata; O_x_rvalid high the following cycle only. rdata held until next read grant of that side.
- Write: commits at grant edge; a read of same address granted next cycle returns new data.
- Throughput: one access per cycle; each side gets >= 1 grant in any 2 consecutive cycles when both request.
- Asynchronous reset mid-clear or mid-access: immediate return to reset values; clear restarts from 0.

Optional Feature:
MEM_ARB_STATS_EN: adds outputs O_a_cnt, O_b_cnt (16 bits each), counting grants per side, saturating at 16'hFFFF, cleared by reset and by entry to INIT. Without the macro: ports and counters absent, behaviour otherwise identical.

Test Plan:
- C_ADDRSIZE=4: release reset -> O_mem_wen=1 for exactly 16 cycles, addr 0..15, wdata 0; O_init_busy low on cycle 17; no gnt during.
- After init: A writes 0x5A to addr 3 (gnt same cycle), then A reads addr 3 -> O_a_rvalid one cycle later, O_a_rdata=0x5A.
- A and B request continuously from the same cycle -> gnt order A,B,A,B...; pointer reset gives A first.
- B write 0x33 addr 7 granted cycle n, A read addr 7 granted n+1 -> A rdata=0x33.
- I_init pulse while both requesting -> pending-cycle grant completes, then 16 clear cycles, no gnt, reads of addr 3 afterwards return 0x00.
- Assert I_rst_n low mid-clear (counter=9) -> outputs reset immediately; after release, clear restarts at addr 0; with MEM_ARB_STATS_EN, 5 A grants -> O_a_cnt=5, cleared to 0 by I_init.
